bm_frame_scheduler: RTL and testbench

- Read-side controller for the double-buffered third-image BRAMs filled by the bit-pixel rotator.
- Detects each completed image through the writer's image_number counter and claims the just-filled buffer.
- Sequences the two block matchers (A, B) through thirds 0, 1, 2 of that buffer with start/done handshakes.
- Drives bm_idle and bm_working_buf back to the writer, so the writer stalls instead of overwriting a buffer under use.

---
 rtl/bm_pkg.sv | 15 +
 rtl/bm_frame_scheduler_if.sv | 36 +++
 rtl/bm_frame_scheduler.sv | 125 ++++++++++++
 tb/tb_bm_frame_scheduler.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bm_pkg.sv
// rtl/bm_pkg.sv - shared block-matcher constants and scheduler state encoding
package bm_pkg;

    localparam int NUM_THIRDS = 3;
    localparam int THIRD_W    = 2;
    localparam int IMG_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_FRAME_END
    } bm_state_e;

endpackage

// File: rtl/bm_frame_scheduler_if.sv
// rtl/bm_frame_scheduler_if.sv - writer/matcher handshake bundle seen by the frame scheduler
interface bm_frame_scheduler_if;
    import bm_pkg::*;

    logic [IMG_W-1:0]   image_number;
    logic               bm_idle;
    logic               bm_working_buf;
    logic               bm_start;
    logic [THIRD_W-1:0] bm_third;
    logic               bm_buf;
    logic               bm_done_a;
    logic               bm_done_b;

    modport master (
        input  image_number,
        input  bm_done_a,
        input  bm_done_b,
        output bm_idle,
        output bm_working_buf,
        output bm_start,
        output bm_third,
        output bm_buf
    );

    modport slave (
        output image_number,
        output bm_done_a,
        output bm_done_b,
        input  bm_idle,
        input  bm_working_buf,
        input  bm_start,
        input  bm_third,
        input  bm_buf
    );

endinterface

// File: rtl/bm_frame_scheduler.sv
// rtl/bm_frame_scheduler.sv - claims each freshly filled third-image buffer and walks both matchers through its thirds
module bm_frame_scheduler
    import bm_pkg::*;
#(
    parameter int num_thirds     = NUM_THIRDS,
    parameter int timeout_cycles = 2000000,
    parameter int skip_cnt_width = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    bm_frame_scheduler_if.master      bm,
    output logic [skip_cnt_width-1:0] frames_skipped,
    output logic                      timeout_err
);

    localparam int                 TO_W       = $clog2(timeout_cycles);
    localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(timeout_cycles - 1);
    localparam logic [THIRD_W-1:0] THIRD_LAST = THIRD_W'(num_thirds - 1);

    bm_state_e                 state_q, state_d;
    logic [IMG_W-1:0]          last_img_q, last_img_d;
    logic                      work_buf_q, work_buf_d;
    logic [THIRD_W-1:0]        third_q, third_d;
    logic                      done_a_q, done_a_d;
    logic                      done_b_q, done_b_d;
    logic [TO_W-1:0]           to_cnt_q, to_cnt_d;
    logic [skip_cnt_width-1:0] skip_q, skip_d;
    logic                      err_q, err_d;

    logic [IMG_W-1:0]          img_delta;
    logic                      img_new;
    logic [TO_W-1:0]           to_cnt_inc;

    always_comb begin
        state_d    = state_q;
        last_img_d = last_img_q;
        work_buf_d = work_buf_q;
        third_d    = third_q;
        done_a_d   = done_a_q;
        done_b_d   = done_b_q;
        to_cnt_d   = to_cnt_q;
        skip_d     = skip_q;
        err_d      = err_q;

        img_delta  = bm.image_number - last_img_q;
        img_new    = (bm.image_number != last_img_q);
        to_cnt_inc = to_cnt_q + TO_W'(1);

        case (state_q)
            // Frame end shares the detection path with idle so a back-to-back
            // image is claimed without ever raising bm_idle.
            ST_IDLE, ST_FRAME_END: begin
                if (img_new) begin
                    last_img_d = bm.image_number;
                    work_buf_d = ~bm.image_number[0];
                    third_d    = '0;
                    state_d    = ST_START;
                    if (img_delta > IMG_W'(1) && skip_q != '1) begin
                        skip_d = skip_q + skip_cnt_width'(1);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                done_a_d = 1'b0;
                done_b_d = 1'b0;
                to_cnt_d = '0;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                done_a_d = done_a_q | bm.bm_done_a;
                done_b_d = done_b_q | bm.bm_done_b;
                to_cnt_d = to_cnt_inc;
                // Completion is judged on the registered flags, which costs the
                // one idle cycle between the last done and the next start.
                if (done_a_q && done_b_q) begin
                    if (third_q == THIRD_LAST) begin
                        state_d = ST_FRAME_END;
                    end else begin
                        third_d = third_q + THIRD_W'(1);
                        state_d = ST_START;
                    end
                end else if (to_cnt_inc == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_FRAME_END;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            last_img_q <= bm.image_number;
            work_buf_q <= 1'b0;
            third_q    <= '0;
            done_a_q   <= 1'b0;
            done_b_q   <= 1'b0;
            to_cnt_q   <= '0;
            skip_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_img_q <= last_img_d;
            work_buf_q <= work_buf_d;
            third_q    <= third_d;
            done_a_q   <= done_a_d;
            done_b_q   <= done_b_d;
            to_cnt_q   <= to_cnt_d;
            skip_q     <= skip_d;
            err_q      <= err_d;
        end
    end

    assign bm.bm_idle        = (state_q == ST_IDLE);
    assign bm.bm_working_buf = work_buf_q;
    assign bm.bm_start       = (state_q == ST_START);
    assign bm.bm_third       = third_q;
    assign bm.bm_buf         = work_buf_q;
    assign frames_skipped    = skip_q;
    assign timeout_err       = err_q;

endmodule

// File: tb/tb_bm_frame_scheduler.sv
// tb/tb_bm_frame_scheduler.sv - randomized self-checking bench for bm_frame_scheduler
module tb_bm_frame_scheduler;
    import bm_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] frames_skipped;
    logic       timeout_err;

    always #5 clk = ~clk;

    bm_frame_scheduler_if bm ();

    bm_frame_scheduler #(
        .num_thirds     (NUM_THIRDS),
        .timeout_cycles (100),
        .skip_cnt_width (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bm             (bm),
        .frames_skipped (frames_skipped),
        .timeout_err    (timeout_err)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [3:0] m_last;
    int         m_skip;
    logic       m_buf;

    task automatic step();
        @(posedge clk);
        #1;
        bm.bm_done_a = 1'b0;
        bm.bm_done_b = 1'b0;
    endtask

    task automatic model_image(input logic [3:0] v);
        logic [3:0] d;
        d = v - m_last;
        if (d > 4'd1 && m_skip < 255) m_skip++;
        m_last = v;
        m_buf  = ~v[0];
    endtask

    task automatic rand_delays(output int da, output int db);
        da = $urandom_range(1, 30);
        db = ($urandom_range(0, 3) == 0) ? da : $urandom_range(1, 30);
    endtask

    task automatic run_job(input int da, input int db, input logic [1:0] et, input logic eb);
        int m;
        total_cnt++;
        if (bm.bm_start !== 1'b1 || bm.bm_third !== et || bm.bm_buf !== eb || bm.bm_idle !== 1'b0)
            $display("FAIL job_start: start=%b third=%0d buf=%b idle=%b want 1/%0d/%b/0",
                     bm.bm_start, bm.bm_third, bm.bm_buf, bm.bm_idle, et, eb);
        else pass_cnt++;
        m = (da > db) ? da : db;
        for (int c = 1; c <= m; c++) begin
            step();
            if (c == da) bm.bm_done_a = 1'b1;
            if (c == db) bm.bm_done_b = 1'b1;
            total_cnt++;
            if (bm.bm_start !== 1'b0 || bm.bm_third !== et || bm.bm_buf !== eb)
                $display("FAIL job_hold: start=%b third=%0d buf=%b want 0/%0d/%b",
                         bm.bm_start, bm.bm_third, bm.bm_buf, et, eb);
            else pass_cnt++;
        end
    endtask

    task automatic start_image(input logic [3:0] v);
        total_cnt++;
        if (bm.bm_idle !== 1'b1) $display("FAIL pre_idle: got %b want 1", bm.bm_idle);
        else pass_cnt++;
        bm.image_number = v;
        step();
        model_image(v);
        total_cnt++;
        if (bm.bm_idle !== 1'b0 || bm.bm_start !== 1'b1 || bm.bm_third !== 2'd0 ||
            bm.bm_working_buf !== m_buf || bm.bm_buf !== m_buf)
            $display("FAIL claim: idle=%b start=%b third=%0d wbuf=%b buf=%b want 0/1/0/%b/%b",
                     bm.bm_idle, bm.bm_start, bm.bm_third, bm.bm_working_buf, bm.bm_buf, m_buf, m_buf);
        else pass_cnt++;
        total_cnt++;
        if (frames_skipped !== 8'(m_skip))
            $display("FAIL skip_count: got %0d want %0d", frames_skipped, m_skip);
        else pass_cnt++;
    endtask

    // Called on a bm_start cycle for third 0; returns on the next start (chained) or idle.
    task automatic run_frame(input int change_at, input logic [3:0] new_img, input bit fixed_first);
        logic fb;
        int   da, db;
        fb = m_buf;
        for (int t = 0; t < NUM_THIRDS; t++) begin
            if (t == change_at) bm.image_number = new_img;
            if (fixed_first && t == 0) begin
                da = 5;
                db = 40;
            end else rand_delays(da, db);
            run_job(da, db, 2'(t), fb);
            step();
            total_cnt++;
            if (bm.bm_start !== 1'b0 || bm.bm_idle !== 1'b0)
                $display("FAIL gap: start=%b idle=%b want 0/0", bm.bm_start, bm.bm_idle);
            else pass_cnt++;
            step();
            if (t < NUM_THIRDS - 1) begin
                total_cnt++;
                if (bm.bm_start !== 1'b1 || bm.bm_third !== 2'(t + 1))
                    $display("FAIL next_start: start=%b third=%0d want 1/%0d", bm.bm_start, bm.bm_third, t + 1);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (bm.bm_start !== 1'b0 || bm.bm_idle !== 1'b0 || bm.bm_working_buf !== fb)
            $display("FAIL frame_end: start=%b idle=%b wbuf=%b want 0/0/%b",
                     bm.bm_start, bm.bm_idle, bm.bm_working_buf, fb);
        else pass_cnt++;
        step();
        if (change_at >= 0) begin
            model_image(new_img);
            total_cnt++;
            if (bm.bm_start !== 1'b1 || bm.bm_idle !== 1'b0 || bm.bm_third !== 2'd0 ||
                bm.bm_working_buf !== m_buf || bm.bm_buf !== m_buf || frames_skipped !== 8'(m_skip))
                $display("FAIL chain: start=%b idle=%b third=%0d wbuf=%b skip=%0d want 1/0/0/%b/%0d",
                         bm.bm_start, bm.bm_idle, bm.bm_third, bm.bm_working_buf, frames_skipped, m_buf, m_skip);
            else pass_cnt++;
        end else begin
            total_cnt++;
            if (bm.bm_idle !== 1'b1 || bm.bm_start !== 1'b0)
                $display("FAIL back_idle: idle=%b start=%b want 1/0", bm.bm_idle, bm.bm_start);
            else pass_cnt++;
        end
    endtask

    task automatic check_reset_values(input string tag);
        total_cnt++;
        if (bm.bm_idle !== 1'b1 || bm.bm_working_buf !== 1'b0 || bm.bm_start !== 1'b0 ||
            bm.bm_third !== 2'd0 || bm.bm_buf !== 1'b0 || frames_skipped !== 8'd0 || timeout_err !== 1'b0)
            $display("FAIL %s: idle=%b wbuf=%b start=%b third=%0d buf=%b skip=%0d err=%b want 1/0/0/0/0/0/0",
                     tag, bm.bm_idle, bm.bm_working_buf, bm.bm_start, bm.bm_third, bm.bm_buf,
                     frames_skipped, timeout_err);
        else pass_cnt++;
    endtask

    task automatic quiet_cycles(input int n, input logic exp_err);
        for (int i = 0; i < n; i++) begin
            step();
            total_cnt++;
            if (bm.bm_start !== 1'b0 || bm.bm_idle !== 1'b1 || timeout_err !== exp_err)
                $display("FAIL quiet: start=%b idle=%b err=%b want 0/1/%b", bm.bm_start, bm.bm_idle, timeout_err, exp_err);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset();
        reset           = 1'b1;
        bm.image_number = 4'd0;
        bm.bm_done_a    = 1'b0;
        bm.bm_done_b    = 1'b0;
        repeat (3) step();
        reset  = 1'b0;
        m_last = 4'd0;
        m_skip = 0;
        m_buf  = 1'b0;
        check_reset_values("reset_values");
        quiet_cycles(6, 1'b0);
    endtask

    task automatic test_basic_frame();
        start_image(4'd1);
        run_frame(-1, 4'd0, 1'b1);
    endtask

    task automatic test_back_to_back();
        start_image(m_last + 4'd1);
        run_frame(1, m_last + 4'd1, 1'b0);
        run_frame(-1, 4'd0, 1'b0);
    endtask

    task automatic test_skip_and_wrap();
        start_image(4'd5);
        run_frame(-1, 4'd0, 1'b0);
        start_image(4'd15);
        run_frame(-1, 4'd0, 1'b0);
        start_image(4'd0);
        run_frame(-1, 4'd0, 1'b0);
    endtask

    task automatic test_random_frames();
        logic [3:0] nv;
        int         ch;
        for (int i = 0; i < 6; i++) begin
            start_image(m_last + 4'($urandom_range(1, 3)));
            ch = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 2));
            nv = m_last + 4'($urandom_range(1, 3));
            run_frame(ch, nv, 1'b0);
            if (ch >= 0) run_frame(-1, 4'd0, 1'b0);
        end
    endtask

    task automatic test_timeout();
        int da, db;
        start_image(m_last + 4'd1);
        rand_delays(da, db);
        run_job(da, db, 2'd0, m_buf);
        step();
        step();
        total_cnt++;
        if (bm.bm_start !== 1'b1 || bm.bm_third !== 2'd1)
            $display("FAIL to_start: start=%b third=%0d want 1/1", bm.bm_start, bm.bm_third);
        else pass_cnt++;
        for (int k = 1; k < 100; k++) begin
            step();
            if (k == 3) bm.bm_done_a = 1'b1;
            total_cnt++;
            if (timeout_err !== 1'b0 || bm.bm_start !== 1'b0 || bm.bm_idle !== 1'b0)
                $display("FAIL to_early: k=%0d err=%b start=%b idle=%b want 0/0/0", k, timeout_err, bm.bm_start, bm.bm_idle);
            else pass_cnt++;
        end
        step();
        total_cnt++;
        if (timeout_err !== 1'b1 || bm.bm_start !== 1'b0 || bm.bm_idle !== 1'b0)
            $display("FAIL to_fire: err=%b start=%b idle=%b want 1/0/0", timeout_err, bm.bm_start, bm.bm_idle);
        else pass_cnt++;
        quiet_cycles(20, 1'b1);
    endtask

    task automatic test_reset_mid_job();
        start_image(m_last + 4'd1);
        step();
        bm.bm_done_b = 1'b1;
        step();
        step();
        reset = 1'b1;
        step();
        check_reset_values("reset_mid");
        reset  = 1'b0;
        m_skip = 0;
        m_buf  = 1'b0;
        step();
        bm.bm_done_a = 1'b1;
        step();
        bm.bm_done_b = 1'b1;
        quiet_cycles(30, 1'b0);
        start_image(m_last + 4'd1);
        run_frame(-1, 4'd0, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_frame();
        test_back_to_back();
        test_skip_and_wrap();
        test_random_frames();
        test_timeout();
        test_reset_mid_job();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
